// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: iterative double-dabble binary-to-BCD converter, one bit per clock; BCD_SATURATE_EN clamps overflowed results to all nines
module bcd_convert_seq #(
    parameter int IN_W   = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int AW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [IN_W-1:0] sh;
    logic [AW-1:0]   acc, adj;
    logic            sticky;
    logic [CW-1:0]   cnt;

    assign ready = state == IDLE;

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // next-state: idle until start, shift IN_W bits, then one publish cycle
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && start)            ? SHIFT :
                  (state == SHIFT && cnt == CW'(1))   ? DONE  :
                  (state == DONE)                     ? IDLE  : state;
    end

    // add-3 correction on every digit that would overflow when doubled
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    // datapath: load, shift with sticky carry-out of the top digit, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            sh       <= '0;
            acc      <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            valid    <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= state == DONE;
            if (state == IDLE && start) begin
                sh     <= bin_in;
                acc    <= '0;
                sticky <= 1'b0;
                cnt    <= CW'(IN_W);
            end else if (state == SHIFT) begin
                acc    <= {adj[AW-2:0], sh[IN_W-1]};
                sh     <= sh << 1;
                sticky <= sticky | adj[AW-1];
                cnt    <= cnt - CW'(1);
            end else if (state == DONE) begin
                overflow <= sticky;
`ifdef BCD_SATURATE_EN
                bcd_out  <= sticky ? {DIGITS{4'h9}} : acc;
`else
                bcd_out  <= acc;
`endif
            end
        end
    end
endmodule
